// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t       : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand width in bits
package shift_add_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : shift_add_multiplier_pkg

// File: rtl/shift_add_multiplier_if.sv
// Request/result bus of the shift-and-add multiplier.
//   start_valid / start_ready : operand handshake (a, b valid with start_valid)
//   a, b                      : unsigned operands, WIDTH bits each
//   result_valid / result_ready : product handshake
//   product                   : unsigned a*b, 2*WIDTH bits
//   busy                      : multiplier is in RUN or DONE
// master = requester/consumer side, slave = multiplier side.
interface shift_add_multiplier_if
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                 start_valid;
    logic                 start_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 result_valid;
    logic                 result_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output start_valid, a, b, result_ready,
        input  start_ready, result_valid, product, busy
    );

    modport slave (
        input  start_valid, a, b, result_ready,
        output start_ready, result_valid, product, busy
    );

endinterface : shift_add_multiplier_if

// File: rtl/shift_add_multiplier_ripple_carry_adder.sv
// Ripple-carry adder used for every addition in the multiplier datapath.
//   Full_adder         : one-bit full adder (a, b, carry_in -> sum, carry_out)
//   ripple_carry_adder : WIDTH-bit chain of Full_adder cells
//     a, b      : WIDTH-bit addends
//     carry_in  : carry into bit 0
//     sum       : WIDTH-bit sum
//     carry_out : carry out of the top bit
module Full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule : Full_adder

module ripple_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // carry[i] enters bit i; carry[WIDTH] leaves the top bit.
    logic [WIDTH:0] carry;

    assign carry[0]  = carry_in;
    assign carry_out = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        Full_adder u_fa (
            .a         (a[i]),
            .b         (b[i]),
            .carry_in  (carry[i]),
            .sum       (sum[i]),
            .carry_out (carry[i+1])
        );
    end

endmodule : ripple_carry_adder

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of shift_add_multiplier_if (handshakes, operands,
//           product, busy)
// A request is accepted in IDLE; RUN then performs WIDTH add/shift steps
// followed by one terminal cycle with the counter at zero, so result_valid
// rises WIDTH+1 cycles after the accepting edge. The product is held in DONE
// until result_ready.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_multiplier_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t              state_q;
    state_t              state_d;
    logic [WIDTH-1:0]    mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [CNT_W-1:0]    count_q;

    logic                load;
    logic                step;
    logic [WIDTH-1:0]    addend;
    logic [WIDTH-1:0]    sum;
    logic                carry;

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and outputs
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        load             = 1'b0;
        step             = 1'b0;
        bus.start_ready  = 1'b0;
        bus.result_valid = 1'b0;
        bus.busy         = 1'b0;

        case (state_q)
            IDLE: begin
                bus.start_ready = 1'b1;
                if (bus.start_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                // The counter reaching zero ends the run; no arithmetic is
                // done in that terminal cycle.
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                bus.busy         = 1'b1;
                bus.result_valid = 1'b1;
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Add the multiplicand only when the current multiplier bit is set;
    // otherwise add zero so the adder output is the unchanged upper half.
    assign addend = mplier_q[0] ? mcand_q : '0;

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a         (acc_q[2*WIDTH-1:WIDTH]),
        .b         (addend),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (carry)
    );

    // NOTE: the datapath registers are reset too, so product, counter and
    // operands read as zero straight out of reset and after an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (load) begin
            mcand_q  <= bus.a;
            mplier_q <= bus.b;
            acc_q    <= '0;
            count_q  <= CNT_W'(WIDTH);
        end else if (step) begin
            // {carry, sum, lower half} shifted right by one: the carry
            // becomes the new MSB and the LSB of the lower half drops off.
            acc_q    <= {carry, sum, acc_q[WIDTH-1:1]};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            count_q  <= count_q - CNT_W'(1);
        end
    end

    assign bus.product = acc_q;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH = 32).
module tb_shift_add_multiplier;

    localparam int W       = 32;
    localparam int LATENCY = W + 1;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents operands for one cycle; returns at the negedge after the
    // accepting edge.
    task automatic start_op(input string tag, input logic [W-1:0] x,
                            input logic [W-1:0] y);
        @(negedge clk);
        check({tag, " start_ready"}, bus.start_ready, 1);
        bus.start_valid = 1'b1;
        bus.a           = x;
        bus.b           = y;
        @(negedge clk);
        bus.start_valid = 1'b0;
        check({tag, " busy_after_accept"}, bus.busy, 1);
        check({tag, " start_ready_low"}, bus.start_ready, 0);
    endtask

    // Waits (bounded) for result_valid; 'elapsed' is the number of edges
    // already seen since the accepting edge.
    task automatic wait_result(input string tag, input int elapsed,
                               input logic [2*W-1:0] exp);
        int n;
        n = elapsed;
        while (bus.result_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, LATENCY);
        check({tag, " product"}, bus.product, exp);
    endtask

    // Consumes the result with result_ready high and checks the return
    // to IDLE one edge later.
    task automatic consume(input string tag);
        bus.result_ready = 1'b1;
        @(negedge clk);
        check({tag, " idle_ready"}, bus.start_ready, 1);
        check({tag, " idle_valid"}, bus.result_valid, 0);
        check({tag, " idle_busy"}, bus.busy, 0);
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst_n            = 1'b0;
        bus.start_valid  = 1'b0;
        bus.a            = '0;
        bus.b            = '0;
        bus.result_ready = 1'b1;

        // Reset state
        #3;
        check("rst start_ready", bus.start_ready, 1);
        check("rst result_valid", bus.result_valid, 0);
        check("rst busy", bus.busy, 0);
        check("rst product", bus.product, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 * 5, result_ready held high
        start_op("3x5", 32'd3, 32'd5);
        wait_result("3x5", 0, 64'd15);
        consume("3x5");

        // all-ones squared
        start_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("ones", 0, 64'hFFFF_FFFE_0000_0001);
        consume("ones");

        // zero multiplicand keeps the full latency
        start_op("zero", 32'd0, 32'h1234_5678);
        wait_result("zero", 0, 64'd0);
        consume("zero");

        // 7 * 6 with a stalled consumer
        bus.result_ready = 1'b0;
        start_op("7x6", 32'd7, 32'd6);
        wait_result("7x6", 0, 64'd42);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("7x6 hold_valid", bus.result_valid, 1);
            check("7x6 hold_product", bus.product, 64'd42);
        end
        // A request presented on the consuming edge must not be taken.
        bus.start_valid = 1'b1;
        bus.a           = 32'd1;
        bus.b           = 32'd1;
        consume("7x6");
        // Same request, now in IDLE, is accepted on the next edge.
        @(negedge clk);
        bus.start_valid = 1'b0;
        check("1x1 busy_after_accept", bus.busy, 1);
        wait_result("1x1", 0, 64'd1);
        consume("1x1");

        // Second request during RUN is ignored
        start_op("2x4", 32'd2, 32'd4);
        repeat (3) @(negedge clk);
        bus.start_valid = 1'b1;
        bus.a           = 32'd9;
        bus.b           = 32'd9;
        repeat (5) @(negedge clk);
        bus.start_valid = 1'b0;
        wait_result("2x4", 8, 64'd8);
        consume("2x4");
        @(negedge clk);
        check("2x4 no_second_accept", bus.busy, 0);

        // Reset in the middle of RUN
        start_op("abort", 32'd5, 32'd5);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort start_ready", bus.start_ready, 1);
        check("abort result_valid", bus.result_valid, 0);
        check("abort busy", bus.busy, 0);
        check("abort product", bus.product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("abort no_result", bus.result_valid, 0);
            check("abort still_idle", bus.busy, 0);
        end
        start_op("10x10", 32'd10, 32'd10);
        wait_result("10x10", 0, 64'd100);
        consume("10x10");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_add_multiplier

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_valid  input  1  request: operands on a/b are valid.
REQ-005 SHALL have port start_ready  output  1  block can accept a request.
REQ-006 SHALL have port a  input  WIDTH  unsigned multiplicand.
REQ-007 SHALL have port b  input  WIDTH  unsigned multiplier.
REQ-008 SHALL have port result_valid  output  1  product is valid.
REQ-009 SHALL have port result_ready  input  1  consumer accepts the product.
REQ-010 SHALL have port product  output  2*WIDTH  unsigned a*b.
REQ-011 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement FSM with states IDLE, RUN and DONE.
REQ-013 SHALL drive start_ready high only in IDLE, result_valid high only in DONE, and busy high in RUN or DONE.
REQ-014 SHALL accept a request on a rising edge where start_valid and start_ready are both high: latch a into multiplicand register, b into multiplier register, clear accumulator, load counter with WIDTH, IDLE->RUN.
REQ-015 SHALL, each RUN cycle: if multiplier LSB is 1, add multiplicand to accumulator upper WIDTH bits with carry-out kept as bit WIDTH+1; then shift {carry, accumulator} right 1, shift multiplier right 1, decrement counter.
REQ-016 SHALL perform every add through the ripple-carry sub-module; no behavioural "+" in the datapath.
REQ-017 SHALL go RUN->DONE on the edge where counter reaches 0; RUN lasts exactly WIDTH cycles regardless of operand values (zero operands included).
REQ-018 SHALL present result_valid exactly WIDTH+1 cycles after the accepting edge.
REQ-019 SHALL hold product and result_valid stable in DONE until result_ready is high, then go DONE->IDLE on that edge.
REQ-020 SHALL ignore start_valid outside IDLE; no queuing, no change to operands in flight.
REQ-021 SHALL accept no new request in the cycle the result is consumed; next acceptance earliest one cycle later (IDLE).
REQ-022 SHALL produce the full 2*WIDTH-bit product with no overflow or truncation for all operand pairs, including all-ones x all-ones.
REQ-023 SHALL keep product driven from the accumulator; value outside DONE is don't-care for consumers but SHALL be deterministic.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, start_ready 1, result_valid 0, busy 0, product 0, counter 0, all operand registers 0.
REQ-025 SHALL abort any operation in RUN or DONE on reset without producing a result; first request after rst_n release accepted on first rising edge with start_valid high.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default WIDTH constant in the shared package.
REQ-027 SHALL instantiate one sub-module ripple_carry_adder (parameter WIDTH; ports a, b, carry_in, sum, carry_out), built as a chain of WIDTH Full_adder instances with carry_in tied to 0.
REQ-028 SHALL keep the counter ceil(log2(WIDTH+1)) bits wide.

Verification
REQ-029 SHALL cover: a=3, b=5, result_ready held 1 -> result_valid at cycle 33 after accept, product=15, start_ready back high one cycle later.
REQ-030 SHALL cover: a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001.
REQ-031 SHALL cover: a=0, b=0x12345678 -> product=0 after full 32-cycle RUN (latency unchanged).
REQ-032 SHALL cover: a=7, b=6, result_ready low for 10 cycles after DONE -> product=42 and result_valid held stable throughout; IDLE one cycle after result_ready rises.
REQ-033 SHALL cover: second start_valid with a=9,b=9 during RUN of a=2,b=4 -> product=8, second request not accepted.
REQ-034 SHALL cover: rst_n pulsed low at RUN cycle 10 -> all outputs at reset values asynchronously, no result_valid, then a=10,b=10 -> product=100.
